// File: rtl/people_mover.sv
// Sweeps the people grid once per game_step, moving each person one cell or drowning it.
// Latency: 4 cycles per empty cell, up to 9 per moved person; step_done pulses after the last cell.
// Backpressure: none; a game_step that arrives mid-sweep is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-low reset
//   game_step, flood       sweep start pulse, flood level
//   mem_rdata              BRAM read data (1-cycle latency)
//   mem_addr/wdata/we      registered BRAM access port
//   busy, step_done        sweep in progress, end-of-sweep pulse
//   move_count/drown_count results of the last completed sweep
//   overrun                sticky: game_step seen while busy
module people_mover #(
    parameter int unsigned GRID_W     = 96,
    parameter int unsigned GRID_H     = 72,
    parameter int unsigned FLOOD_COLS = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        game_step,
    input  logic        flood,
    input  logic [29:0] mem_rdata,
    output logic [12:0] mem_addr,
    output logic [29:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        step_done,
    output logic [12:0] move_count,
    output logic [12:0] drown_count,
    output logic        overrun
);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, WT_SRC, CK_SRC, RD_DST, WT_DST, CK_DST, WR_DST, WR_SRC, NEXT
    } state_t;

    localparam logic [6:0]  X_MAX = 7'(GRID_W - 1);
    localparam logic [6:0]  Y_MAX = 7'(GRID_H - 1);
    localparam logic [6:0]  FL_LO = 7'(FLOOD_COLS);
    localparam logic [6:0]  FL_HI = 7'(GRID_W - FLOOD_COLS);
    localparam logic [12:0] ROW   = 13'(GRID_W);

    state_t      state, state_nxt;
    logic        parity, parity_nxt;
    logic [15:0] lfsr, lfsr_nxt, lfsr_adv;
    logic [6:0]  x, x_nxt, y, y_nxt;
    logic [12:0] src_addr, src_addr_nxt;
    logic [12:0] dst_addr, dst_addr_nxt;
    logic [28:0] payload, payload_nxt;
    logic [12:0] work_moves, work_moves_nxt;
    logic [12:0] work_drowns, work_drowns_nxt;
    logic [12:0] mem_addr_nxt;
    logic [29:0] mem_wdata_nxt;
    logic        mem_we_nxt;
    logic        step_done_nxt;
    logic [12:0] move_count_nxt, drown_count_nxt;
    logic        overrun_nxt;

    logic [1:0]  dir;
    logic        off_grid;
    logic [6:0]  tgt_x;
    logic [12:0] tgt_addr;

    function automatic logic in_flood(input logic [6:0] col);
        return (col < FL_LO) || (col >= FL_HI);
    endfunction

    // Fibonacci LFSR, taps 16/14/13/11, shifted left with feedback into bit 0.
    assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign dir      = lfsr_adv[1:0];
    assign busy     = (state != IDLE);

    // Candidate target for the direction the advanced LFSR picks.
    always_comb begin
        off_grid = 1'b0;
        tgt_x    = x;
        tgt_addr = src_addr;
        case (dir)
            2'b00: begin off_grid = (y == 7'd0);  tgt_addr = src_addr - ROW;  end
            2'b01: begin off_grid = (x == X_MAX); tgt_x = x + 7'd1; tgt_addr = src_addr + 13'd1; end
            2'b10: begin off_grid = (y == Y_MAX); tgt_addr = src_addr + ROW;  end
            default: begin off_grid = (x == 7'd0); tgt_x = x - 7'd1; tgt_addr = src_addr - 13'd1; end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            parity      <= 1'b0;
            lfsr        <= LFSR_SEED;
            x           <= '0;
            y           <= '0;
            src_addr    <= '0;
            dst_addr    <= '0;
            payload     <= '0;
            work_moves  <= '0;
            work_drowns <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            step_done   <= 1'b0;
            move_count  <= '0;
            drown_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            parity      <= parity_nxt;
            lfsr        <= lfsr_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            src_addr    <= src_addr_nxt;
            dst_addr    <= dst_addr_nxt;
            payload     <= payload_nxt;
            work_moves  <= work_moves_nxt;
            work_drowns <= work_drowns_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_we      <= mem_we_nxt;
            step_done   <= step_done_nxt;
            move_count  <= move_count_nxt;
            drown_count <= drown_count_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        parity_nxt      = parity;
        lfsr_nxt        = lfsr;
        x_nxt           = x;
        y_nxt           = y;
        src_addr_nxt    = src_addr;
        dst_addr_nxt    = dst_addr;
        payload_nxt     = payload;
        work_moves_nxt  = work_moves;
        work_drowns_nxt = work_drowns;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        mem_we_nxt      = 1'b0;
        step_done_nxt   = 1'b0;
        move_count_nxt  = move_count;
        drown_count_nxt = drown_count;
        overrun_nxt     = overrun | (game_step && (state != IDLE));

        case (state)
            IDLE: begin
                if (game_step) begin
                    parity_nxt      = ~parity;
                    work_moves_nxt  = '0;
                    work_drowns_nxt = '0;
                    x_nxt           = '0;
                    y_nxt           = '0;
                    src_addr_nxt    = '0;
                    mem_addr_nxt    = '0;
                    state_nxt       = RD_SRC;
                end
            end
            RD_SRC: state_nxt = WT_SRC;
            WT_SRC: state_nxt = CK_SRC;
            CK_SRC: begin
                // A tag equal to the current parity marks a person already moved into this cell.
                if ((mem_rdata[28:0] == '0) || (mem_rdata[29] == parity)) begin
                    state_nxt = NEXT;
                end else if (flood && in_flood(x)) begin
                    mem_addr_nxt    = src_addr;
                    mem_wdata_nxt   = '0;
                    mem_we_nxt      = 1'b1;
                    work_drowns_nxt = work_drowns + 13'd1;
                    state_nxt       = WR_SRC;
                end else begin
                    lfsr_nxt    = lfsr_adv;
                    payload_nxt = mem_rdata[28:0];
                    if (off_grid || (flood && in_flood(tgt_x))) begin
                        mem_addr_nxt  = src_addr;
                        mem_wdata_nxt = {parity, mem_rdata[28:0]};
                        mem_we_nxt    = 1'b1;
                        state_nxt     = WR_SRC;
                    end else begin
                        dst_addr_nxt = tgt_addr;
                        mem_addr_nxt = tgt_addr;
                        state_nxt    = RD_DST;
                    end
                end
            end
            RD_DST: state_nxt = WT_DST;
            WT_DST: state_nxt = CK_DST;
            CK_DST: begin
                if (mem_rdata[28:0] != '0) begin
                    mem_addr_nxt  = src_addr;
                    mem_wdata_nxt = {parity, payload};
                    mem_we_nxt    = 1'b1;
                    state_nxt     = WR_SRC;
                end else begin
                    mem_addr_nxt   = dst_addr;
                    mem_wdata_nxt  = {parity, payload};
                    mem_we_nxt     = 1'b1;
                    work_moves_nxt = work_moves + 13'd1;
                    state_nxt      = WR_DST;
                end
            end
            WR_DST: begin
                // Destination claimed; now vacate the source.
                mem_addr_nxt  = src_addr;
                mem_wdata_nxt = '0;
                mem_we_nxt    = 1'b1;
                state_nxt     = WR_SRC;
            end
            WR_SRC: state_nxt = NEXT;
            NEXT: begin
                if ((x == X_MAX) && (y == Y_MAX)) begin
                    move_count_nxt  = work_moves;
                    drown_count_nxt = work_drowns;
                    step_done_nxt   = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    if (x == X_MAX) begin
                        x_nxt = '0;
                        y_nxt = y + 7'd1;
                    end else begin
                        x_nxt = x + 7'd1;
                    end
                    src_addr_nxt = src_addr + 13'd1;
                    mem_addr_nxt = src_addr + 13'd1;
                    state_nxt    = RD_SRC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/people_mover.md
Name: people_mover

Overview:
- Upstream stage of the island renderer. Owns the write side of the people BRAM: 96x72 grid, one 30-bit word per cell, address = 96*y + x.
- On each game_step it sweeps every cell. Each occupied person moves one grid space in a pseudo-random direction.
- While flood is high, people in flooded columns are drowned.
- Completes well inside one 65 MHz XGA frame, so the display port always sees a consistent grid.

Parameters:
GRID_W, 96, grid columns
GRID_H, 72, grid rows
FLOOD_COLS, 16, columns at each island edge that are under water while flood=1 (x<16 or x>=80)
LFSR_SEED, 16'hACE1, LFSR value after reset

Ports:
clk_in  in  1  65 MHz system clock
rst_in  in  1  reset, asynchronous, active-low
game_step  in  1  one-cycle pulse; starts a sweep
flood  in  1  level; flood active
mem_rdata  in  30  BRAM read data, 1-cycle latency from sampled address
mem_addr  out  13  BRAM address, registered
mem_wdata  out  30  BRAM write data, registered
mem_we  out  1  BRAM write enable, registered
busy  out  1  high from the cycle after an accepted game_step until the cycle step_done is asserted
step_done  out  1  one-cycle pulse at sweep end
move_count  out  13  people moved in the last completed sweep
drown_count  out  13  people drowned in the last completed sweep
overrun  out  1  sticky; game_step arrived while busy

Behaviour:
- Reset: all outputs 0. State IDLE. parity=0, lfsr=LFSR_SEED, x=y=0. BRAM contents untouched.
- Reset mid-sweep: mem_we drops immediately (async). The sweep is abandoned.
- Cell format:
  - bit 29 = step tag; bits 28:0 = payload.
  - A cell is occupied iff payload != 0. Empty cells are always written as 30'h0.
- Sweep start: game_step in IDLE toggles parity, clears working counters, sets x=y=0, and enters RD_SRC. game_step while not IDLE is dropped and sets overrun.
- States: IDLE, RD_SRC, WT_SRC, CK_SRC, RD_DST, WT_DST, CK_DST, WR_DST, WR_SRC, NEXT.
- Read timing: mem_addr is loaded on entry to RD_*. The BRAM samples it the following edge. mem_rdata is valid in CK_*. WT_* is a single wait cycle.
- CK_SRC, first match wins:
  - Payload 0 -> NEXT.
  - Tag == parity (already moved this sweep) -> NEXT.
  - flood=1 and x<FLOOD_COLS or x>=GRID_W-FLOOD_COLS -> write 30'h0 to src (WR_SRC), drown +1.
  - Otherwise advance the LFSR once. It is 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
  - Direction is taken from the new lfsr[1:0]: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
  - Target off-grid, or (flood=1 and target in a flooded column) -> write {parity,payload} back to src (stay).
  - Otherwise go to RD_DST with target address = src±1 or src±96.
- CK_DST:
  - Target payload != 0 -> stay (rewrite src with tag).
  - Target empty -> WR_DST writes {parity,payload} to target, then WR_SRC writes 30'h0 to src, moves +1.
- Writes: mem_we is high exactly one cycle per write state, with mem_addr and mem_wdata valid that cycle. There are no reads and writes in the same cycle.
- NEXT:
  - If x==GRID_W-1, set x=0 and y+1; otherwise x+1.
  - After cell (95,71): latch working counts into move_count and drown_count, pulse step_done, clear busy, go to IDLE.
- Counters are 13-bit and cannot overflow (at most 6912 cells).
- flood is sampled live in each CK_SRC. A flood edge mid-sweep affects only cells not yet visited.
- Worst case is about 10 cycles/cell, ≈69k cycles per sweep, well under one frame (~1.08M cycles).

Test Plan:
- Reset with rst_in=0 mid-sweep -> mem_we=0 within the same cycle. After release: busy=0, outputs 0, lfsr=16'hACE1.
- Empty BRAM, one game_step -> zero writes; step_done after 6912 cells; move_count=0, drown_count=0.
- Single person 30'h0000_0005 at (40,30), addr 2920, one step -> exactly one move to an adjacent address chosen by the first LFSR direction; source reads 0; destination reads {1'b1,payload}; move_count=1.
- Person at (0,0) with a direction of up or left -> stays at addr 0, tag set to 1, move_count=0.
- Two persons at addr 2920 and 2921 with direction right for 2920 -> 2920 stays, since 2921 is occupied. 2921 is processed exactly once (tag check).
- flood=1 with persons at x=5 and x=50 -> x=5 cell becomes 30'h0, drown_count=1, x=50 person never enters columns 0-15 or 80-95. Second game_step while busy -> overrun=1.
